output_writeback: RTL and testbench

- Downstream of the convolution core in top_system.
- Consumes the core's output stream: one accumulated result per beat, tagged with x/y/ch coordinates.
- Computes each result's external-memory address, buffers results in a small FIFO, and issues ready/valid-handshaked writes to the external memory port.
- Signals completion once every expected output of the layer has been written.

---
 rtl/output_writeback.sv | 168 ++++++++++++++++
 tb/tb_output_writeback.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_writeback.sv
// Output writeback: addresses convolution results, buffers them and writes them to external memory.
// Optional output saturation is enabled by defining WB_SATURATE_EN.
module output_writeback #(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int IO_DATA_WIDTH      = 16,
    parameter int EXT_MEM_HEIGHT     = 1 << 20,
    parameter int EXT_MEM_WIDTH      = 32,
    parameter int FEATURE_MAP_WIDTH  = 64,
    parameter int FEATURE_MAP_HEIGHT = 64,
    parameter int OUTPUT_NB_CHANNELS = 32,
    parameter int FIFO_DEPTH         = 4,
    parameter int BASE_ADDR          = 0,
    localparam int ADDR_W = $clog2(EXT_MEM_HEIGHT),
    localparam int XW = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
    localparam int YW = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
    localparam int CW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    input  logic [ACCUMULATION_WIDTH-1:0] in_data,
    input  logic                          in_valid,
    input  logic [XW-1:0]                 in_x,
    input  logic [YW-1:0]                 in_y,
    input  logic [CW-1:0]                 in_ch,
    output logic                          in_ready,
    output logic                          mem_write_en,
    output logic [ADDR_W-1:0]             mem_write_addr,
    output logic [EXT_MEM_WIDTH-1:0]      mem_write_data,
    input  logic                          mem_ready,
    output logic                          running,
    output logic                          done,
    output logic                          range_error
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_RUN   | accepting result beats until the layer total is reached
    // S_DRAIN | no more input; flushing address stage and FIFO
    // S_DONE  | one-cycle completion pulse

    localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
    localparam int TW    = $clog2(TOTAL + 1);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int OW    = PW + 1;
    localparam int NW    = OW + 1;

    if (EXT_MEM_WIDTH < ACCUMULATION_WIDTH || IO_DATA_WIDTH < 2 ||
        IO_DATA_WIDTH > ACCUMULATION_WIDTH || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("output_writeback: unsupported parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;

    logic [TW-1:0]                   remaining;
    logic                            accept, in_range, last_beat;
    logic                            push, pop, fifo_empty;
    logic [NW-1:0]                   occ_need;
    logic [ADDR_W-1:0]               addr_calc;
    logic signed [ACCUMULATION_WIDTH-1:0] acc_val;
    logic [EXT_MEM_WIDTH-1:0]        ext_data;

    logic                            st_valid;
    logic [ADDR_W-1:0]               st_addr;
    logic [EXT_MEM_WIDTH-1:0]        st_data;

    logic [ADDR_W-1:0]               fifo_addr [FIFO_DEPTH];
    logic [EXT_MEM_WIDTH-1:0]        fifo_data [FIFO_DEPTH];
    logic [PW-1:0]                   wr_ptr, rd_ptr;
    logic [OW-1:0]                   fifo_cnt;

    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = !fifo_empty && mem_ready;
    assign push       = st_valid;

    // Room must cover the incoming beat plus whatever the address stage pushes this cycle.
    assign occ_need  = NW'(fifo_cnt) - NW'(pop) + NW'(st_valid) + NW'(1);
    assign in_ready  = (state == S_RUN) && (occ_need <= NW'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign last_beat = (remaining == TW'(1));

    assign in_range = (32'(in_x)  < 32'(FEATURE_MAP_WIDTH))  &&
                      (32'(in_y)  < 32'(FEATURE_MAP_HEIGHT)) &&
                      (32'(in_ch) < 32'(OUTPUT_NB_CHANNELS));

    // Modular ADDR_W arithmetic yields the same low bits as the full-precision sum.
    assign addr_calc = ADDR_W'(BASE_ADDR) +
                       (ADDR_W'(in_y) * ADDR_W'(FEATURE_MAP_WIDTH) + ADDR_W'(in_x)) *
                       ADDR_W'(OUTPUT_NB_CHANNELS) + ADDR_W'(in_ch);

`ifdef WB_SATURATE_EN
    localparam logic signed [ACCUMULATION_WIDTH-1:0] SAT_MAX =
        ACCUMULATION_WIDTH'((64'sd1 <<< (IO_DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACCUMULATION_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        acc_val = $signed(in_data);
        if ($signed(in_data) > SAT_MAX) begin
            acc_val = SAT_MAX;
        end else if ($signed(in_data) < SAT_MIN) begin
            acc_val = SAT_MIN;
        end
    end
`else
    assign acc_val = $signed(in_data);
`endif

    assign ext_data = EXT_MEM_WIDTH'(acc_val);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && last_beat) state_nxt = S_DRAIN;
            S_DRAIN: if (fifo_empty && !st_valid) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state       <= S_IDLE;
            remaining   <= '0;
            range_error <= 1'b0;
            st_valid    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                remaining   <= TW'(TOTAL);
                range_error <= 1'b0;
            end else if (accept) begin
                remaining <= remaining - TW'(1);
            end
            if (accept && !in_range) begin
                range_error <= 1'b1;
            end
            st_valid <= accept && in_range;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt <= fifo_cnt + OW'(push) - OW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            st_addr <= addr_calc;
            st_data <= ext_data;
        end
        if (push) begin
            fifo_addr[wr_ptr] <= st_addr;
            fifo_data[wr_ptr] <= st_data;
        end
    end

    assign mem_write_en   = !fifo_empty;
    assign mem_write_addr = fifo_addr[rd_ptr];
    assign mem_write_data = fifo_data[rd_ptr];
    assign running        = (state == S_RUN) || (state == S_DRAIN);
    assign done           = (state == S_DONE);

endmodule

// File: tb/tb_output_writeback.sv
// Directed bench for output_writeback: default, 2x2x2 and 2x2x3 instances share clock and reset.
module tb_output_writeback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_n;
    int   total  = 0;
    int   passed = 0;

    // default-parameter instance
    logic        d_start, d_in_valid, d_in_ready, d_mem_ready, d_en, d_running, d_done, d_rerr;
    logic [31:0] d_in_data, d_wdata;
    logic [5:0]  d_x, d_y;
    logic [4:0]  d_ch;
    logic [19:0] d_addr;

    // 2x2x2 instance
    logic        s_start, s_in_valid, s_in_ready, s_mem_ready, s_en, s_running, s_done, s_rerr;
    logic [31:0] s_in_data, s_wdata;
    logic        s_x, s_y, s_ch;
    logic [19:0] s_addr;

    // 2x2x3 instance, channel 3 is representable but out of range
    logic        r_start, r_in_valid, r_in_ready, r_mem_ready, r_en, r_running, r_done, r_rerr;
    logic [31:0] r_in_data, r_wdata;
    logic        r_x, r_y;
    logic [1:0]  r_ch;
    logic [19:0] r_addr;

    output_writeback u_def (
        .clk(clk), .arst_n_in(arst_n), .start(d_start), .in_data(d_in_data), .in_valid(d_in_valid),
        .in_x(d_x), .in_y(d_y), .in_ch(d_ch), .in_ready(d_in_ready), .mem_write_en(d_en),
        .mem_write_addr(d_addr), .mem_write_data(d_wdata), .mem_ready(d_mem_ready),
        .running(d_running), .done(d_done), .range_error(d_rerr)
    );

    output_writeback #(.FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(2)) u_small (
        .clk(clk), .arst_n_in(arst_n), .start(s_start), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_x(s_x), .in_y(s_y), .in_ch(s_ch), .in_ready(s_in_ready), .mem_write_en(s_en),
        .mem_write_addr(s_addr), .mem_write_data(s_wdata), .mem_ready(s_mem_ready),
        .running(s_running), .done(s_done), .range_error(s_rerr)
    );

    output_writeback #(.FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(3)) u_rng (
        .clk(clk), .arst_n_in(arst_n), .start(r_start), .in_data(r_in_data), .in_valid(r_in_valid),
        .in_x(r_x), .in_y(r_y), .in_ch(r_ch), .in_ready(r_in_ready), .mem_write_en(r_en),
        .mem_write_addr(r_addr), .mem_write_data(r_wdata), .mem_ready(r_mem_ready),
        .running(r_running), .done(r_done), .range_error(r_rerr)
    );

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (d_in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", d_in_ready); else passed++;
        total++; if (d_en !== 1'b0) $display("FAIL rst_mem_write_en got %b exp 0", d_en); else passed++;
        total++; if (d_done !== 1'b0) $display("FAIL rst_done got %b exp 0", d_done); else passed++;
        total++; if (d_rerr !== 1'b0) $display("FAIL rst_range_error got %b exp 0", d_rerr); else passed++;
        total++; if (d_running !== 1'b0) $display("FAIL rst_running got %b exp 0", d_running); else passed++;
        total++; if (s_en !== 1'b0 || s_running !== 1'b0) $display("FAIL rst_small got en=%b run=%b exp 0 0", s_en, s_running); else passed++;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_basic_address();
        @(negedge clk);
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        d_mem_ready = 1'b1;
        d_x = 6'd1; d_y = 6'd0; d_ch = 5'd2; d_in_data = 32'd7; d_in_valid = 1'b1;
        #1;
        total++; if (d_running !== 1'b1) $display("FAIL basic_running got %b exp 1", d_running); else passed++;
        total++; if (d_in_ready !== 1'b1) $display("FAIL basic_in_ready got %b exp 1", d_in_ready); else passed++;
        @(negedge clk);
        d_in_valid = 1'b0;
        #1;
        total++; if (d_en !== 1'b0) $display("FAIL basic_latency_n1 got en=%b exp 0", d_en); else passed++;
        @(negedge clk);
        #1;
        total++; if (d_en !== 1'b1) $display("FAIL basic_latency_n2 got en=%b exp 1", d_en); else passed++;
        total++; if (d_addr !== 20'd34) $display("FAIL basic_addr got %0d exp 34", d_addr); else passed++;
        total++; if (d_wdata !== 32'd7) $display("FAIL basic_data got %0d exp 7", d_wdata); else passed++;
        @(negedge clk);
        #1;
        total++; if (d_en !== 1'b0) $display("FAIL basic_single_write got en=%b exp 0", d_en); else passed++;
    endtask

    task automatic test_saturation();
        logic [31:0] exp_data [2];
        int n = 0;
`ifdef WB_SATURATE_EN
        exp_data[0] = 32'd32767;
        exp_data[1] = 32'hFFFF8000;
`else
        exp_data[0] = 32'd40000;
        exp_data[1] = 32'hFFFF63C0;
`endif
        @(negedge clk);
        d_x = 6'd0; d_y = 6'd1; d_ch = 5'd0; d_in_data = 32'd40000; d_in_valid = 1'b1;
        @(negedge clk);
        d_ch = 5'd1; d_in_data = -32'sd40000;
        @(negedge clk);
        d_in_valid = 1'b0;
        for (int c = 0; c < 10 && n < 2; c++) begin
            #1;
            if (d_en) begin
                total++; if (d_addr !== 20'(2048 + n)) $display("FAIL sat_addr%0d got %0d exp %0d", n, d_addr, 2048 + n); else passed++;
                total++; if (d_wdata !== exp_data[n]) $display("FAIL sat_data%0d got %h exp %h", n, d_wdata, exp_data[n]); else passed++;
                n++;
            end
            @(negedge clk);
        end
        total++; if (n != 2) $display("FAIL sat_write_count got %0d exp 2", n); else passed++;
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int wr = 0;
        d_mem_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (sent < 8) begin
                d_x = 6'(sent); d_y = 6'd2; d_ch = 5'd3; d_in_data = 32'(100 + sent); d_in_valid = 1'b1;
            end else begin
                d_in_valid = 1'b0;
            end
            #1;
            if (d_in_valid && d_in_ready) sent++;
            @(negedge clk);
        end
        #1;
        total++; if (sent != 4) $display("FAIL bp_accepted got %0d exp 4", sent); else passed++;
        total++; if (d_in_ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", d_in_ready); else passed++;
        total++; if (d_en !== 1'b1 || d_addr !== 20'd4099) $display("FAIL bp_head got en=%b addr=%0d exp 1 4099", d_en, d_addr); else passed++;
        @(negedge clk);
        d_mem_ready = 1'b1;
        for (int c = 0; c < 40 && wr < 8; c++) begin
            if (sent < 8) begin
                d_x = 6'(sent); d_y = 6'd2; d_ch = 5'd3; d_in_data = 32'(100 + sent); d_in_valid = 1'b1;
            end else begin
                d_in_valid = 1'b0;
            end
            #1;
            if (d_en) begin
                total++; if (d_addr !== 20'(4099 + 32 * wr) || d_wdata !== 32'(100 + wr))
                    $display("FAIL bp_write%0d got addr=%0d data=%0d exp %0d %0d", wr, d_addr, d_wdata, 4099 + 32 * wr, 100 + wr);
                else passed++;
                wr++;
            end
            if (d_in_valid && d_in_ready) sent++;
            @(negedge clk);
        end
        d_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (wr != 8 || sent != 8) $display("FAIL bp_counts got wr=%0d sent=%0d exp 8 8", wr, sent); else passed++;
        total++; if (d_en !== 1'b0) $display("FAIL bp_no_duplicate got en=%b exp 0", d_en); else passed++;
    endtask

    task automatic run_small_layer(input bit rand_ready);
        int sent = 0;
        int wr = 0;
        int dn = 0;
        int after = 0;
        logic [31:0] expd;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int c = 0; c < 150 && after < 3; c++) begin
            if (sent < 8) begin
                s_x = sent[1]; s_y = sent[2]; s_ch = sent[0]; s_in_data = 32'(sent * 7 - 20); s_in_valid = 1'b1;
            end else begin
                s_in_valid = 1'b0;
            end
            s_mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (s_done) begin
                dn++;
                total++; if (wr != 8) $display("FAIL cpl_done_early got writes=%0d exp 8", wr); else passed++;
            end
            if (s_en && s_mem_ready) begin
                expd = 32'(wr * 7 - 20);
                total++; if (s_addr !== 20'(wr) || s_wdata !== expd)
                    $display("FAIL cpl_write%0d got addr=%0d data=%h exp %0d %h", wr, s_addr, s_wdata, wr, expd);
                else passed++;
                wr++;
            end
            if (s_in_valid && s_in_ready) sent++;
            @(negedge clk);
            if (dn > 0) after++;
        end
        #1;
        total++; if (wr != 8) $display("FAIL cpl_write_count got %0d exp 8", wr); else passed++;
        total++; if (dn != 1) $display("FAIL cpl_done_pulses got %0d exp 1", dn); else passed++;
        total++; if (s_running !== 1'b0 || s_in_ready !== 1'b0 || s_en !== 1'b0)
            $display("FAIL cpl_idle got run=%b rdy=%b en=%b exp 0 0 0", s_running, s_in_ready, s_en);
        else passed++;
    endtask

    task automatic test_range_error();
        int wr = 0;
        int dn = 0;
        int after = 0;
        int sent = 1;
        @(negedge clk);
        r_start = 1'b1;
        @(negedge clk);
        r_start = 1'b0;
        r_mem_ready = 1'b1;
        r_x = 1'b0; r_y = 1'b0; r_ch = 2'd3; r_in_data = 32'd55; r_in_valid = 1'b1;
        #1;
        total++; if (r_in_ready !== 1'b1) $display("FAIL rng_in_ready got %b exp 1", r_in_ready); else passed++;
        @(negedge clk);
        r_in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (r_en) wr++;
            @(negedge clk);
        end
        #1;
        total++; if (wr != 0) $display("FAIL rng_dropped got writes=%0d exp 0", wr); else passed++;
        total++; if (r_rerr !== 1'b1) $display("FAIL rng_flag got %b exp 1", r_rerr); else passed++;
        for (int c = 0; c < 80 && after < 3; c++) begin
            if (sent < 12) begin
                if (sent == 1) begin r_x = 1'b1; r_y = 1'b1; r_ch = 2'd2; r_in_data = 32'd9; end
                else begin r_x = 1'b0; r_y = 1'b0; r_ch = 2'd3; r_in_data = 32'(sent); end
                r_in_valid = 1'b1;
            end else begin
                r_in_valid = 1'b0;
            end
            #1;
            if (r_done) dn++;
            if (r_en) begin
                total++; if (r_addr !== 20'd11 || r_wdata !== 32'd9)
                    $display("FAIL rng_write got addr=%0d data=%0d exp 11 9", r_addr, r_wdata);
                else passed++;
                wr++;
            end
            if (r_in_valid && r_in_ready) sent++;
            @(negedge clk);
            if (dn > 0) after++;
        end
        #1;
        total++; if (wr != 1) $display("FAIL rng_write_count got %0d exp 1", wr); else passed++;
        total++; if (dn != 1) $display("FAIL rng_done_pulses got %0d exp 1", dn); else passed++;
        total++; if (r_rerr !== 1'b1) $display("FAIL rng_sticky got %b exp 1", r_rerr); else passed++;
        @(negedge clk);
        r_start = 1'b1;
        @(negedge clk);
        r_start = 1'b0;
        #1;
        total++; if (r_rerr !== 1'b0 || r_running !== 1'b1)
            $display("FAIL rng_cleared got err=%b run=%b exp 0 1", r_rerr, r_running);
        else passed++;
    endtask

    task automatic test_reset_midrun();
        int sent = 0;
        int en_seen = 0;
        int dn = 0;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_mem_ready = 1'b0;
        for (int c = 0; c < 10 && sent < 3; c++) begin
            s_x = sent[1]; s_y = sent[2]; s_ch = sent[0]; s_in_data = 32'(sent); s_in_valid = 1'b1;
            #1;
            if (s_in_ready) sent++;
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (s_en !== 1'b1) $display("FAIL mid_buffered got en=%b exp 1", s_en); else passed++;
        @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        s_mem_ready = 1'b1;
        #1;
        total++; if (s_en !== 1'b0 || s_in_ready !== 1'b0 || s_running !== 1'b0 || s_done !== 1'b0)
            $display("FAIL mid_reset got en=%b rdy=%b run=%b done=%b exp 0 0 0 0", s_en, s_in_ready, s_running, s_done);
        else passed++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (s_en) en_seen++;
            if (s_done) dn++;
        end
        total++; if (en_seen != 0 || dn != 0) $display("FAIL mid_quiet got en_cycles=%0d done=%0d exp 0 0", en_seen, dn); else passed++;
        run_small_layer(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        arst_n = 1'b0;
        d_start = 0; d_in_valid = 0; d_mem_ready = 0; d_in_data = '0; d_x = '0; d_y = '0; d_ch = '0;
        s_start = 0; s_in_valid = 0; s_mem_ready = 0; s_in_data = '0; s_x = '0; s_y = '0; s_ch = '0;
        r_start = 0; r_in_valid = 0; r_mem_ready = 0; r_in_data = '0; r_x = '0; r_y = '0; r_ch = '0;
        test_reset();
        test_basic_address();
        test_saturation();
        test_backpressure();
        run_small_layer(1'b1);
        test_range_error();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
